// File: rtl/zx48_timing_pkg.sv
// 48K frame timing constants and shared scheduler types.
// Build switch CPU_CONTENTION_EN enables the ULA contention stall FSM.
package zx48_timing_pkg;

    localparam int CLK_DIV     = 8;
    localparam int LINE_T      = 224;
    localparam int FRAME_LINES = 312;
    localparam int INT_LEN     = 32;
    localparam int CONT_LINE0  = 64;
    localparam int CONT_LINES  = 192;
    localparam int CONT_COLS   = 128;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } sched_state_t;

    // Contended RAM lives in the 0x4000-0x7FFF page.
    function automatic logic is_contended_addr(input logic [15:0] a);
        return a[15:14] == 2'b01;
    endfunction

endpackage

// File: rtl/cpu_clock_scheduler_if.sv
// CPU-side bus between the Z80 core and the clock scheduler.
// Master is the CPU, slave is the scheduler.
interface cpu_clock_scheduler_if;

    logic [15:0] a;
    logic        mreq;
    logic        iorq;
    logic        cep;
    logic        cen;
    logic        int_n;
    logic        contended;

    modport master (
        output a, mreq, iorq,
        input  cep, cen, int_n, contended
    );

    modport slave (
        input  a, mreq, iorq,
        output cep, cen, int_n, contended
    );

endinterface

// File: rtl/ula_tcounter.sv
// Phase, column and line counters for the 48K frame; tick marks phase 0.
// Shared with the video block so fetch and contention stay aligned.
module ula_tcounter #(
    parameter int CLK_DIV     = zx48_timing_pkg::CLK_DIV,
    parameter int LINE_T      = zx48_timing_pkg::LINE_T,
    parameter int FRAME_LINES = zx48_timing_pkg::FRAME_LINES
) (
    input  logic       clock,
    input  logic       reset,
    output logic       tick,
    output logic       mid,
    output logic [8:0] line,
    output logic [7:0] col
);
    import zx48_timing_pkg::*;

    localparam int PW = $clog2(CLK_DIV);
    localparam logic [PW-1:0] PHASE_LAST = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] PHASE_MID  = PW'(CLK_DIV / 2);
    localparam logic [7:0]    COL_LAST   = 8'(LINE_T - 1);
    localparam logic [8:0]    LINE_LAST  = 9'(FRAME_LINES - 1);

    logic [PW-1:0] phase;

    assign tick = (phase == '0);
    assign mid  = (phase == PHASE_MID);

    always_ff @(posedge clock) begin
        if (reset) begin
            phase <= '0;
            col   <= '0;
            line  <= '0;
        end else begin
            phase <= (phase == PHASE_LAST) ? '0 : phase + 1'b1;
            if (tick) begin
                if (col == COL_LAST) begin
                    col  <= '0;
                    line <= (line == LINE_LAST) ? '0 : line + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/cpu_clock_scheduler.sv
// Z80 clock-enable generator with frame interrupt and ULA contention stalls.
// Build switch CPU_CONTENTION_EN enables the stall FSM; otherwise the CPU free-runs.
//
//   state | meaning
//   RUN   | cep issued on every tick unless a contended access hits the window
//   STALL | cep withheld until the first tick outside the contention window
module cpu_clock_scheduler #(
    parameter int CLK_DIV     = zx48_timing_pkg::CLK_DIV,
    parameter int LINE_T      = zx48_timing_pkg::LINE_T,
    parameter int FRAME_LINES = zx48_timing_pkg::FRAME_LINES,
    parameter int INT_LEN     = zx48_timing_pkg::INT_LEN,
    parameter int CONT_LINE0  = zx48_timing_pkg::CONT_LINE0,
    parameter int CONT_LINES  = zx48_timing_pkg::CONT_LINES,
    parameter int CONT_COLS   = zx48_timing_pkg::CONT_COLS
) (
    input  logic                    clock,
    input  logic                    reset,
    cpu_clock_scheduler_if.slave    bus,
    output logic [8:0]              line,
    output logic [7:0]              col
);
    import zx48_timing_pkg::*;

    localparam logic [7:0] INT_COLS = 8'(INT_LEN);

    logic tick;
    logic mid;
    logic cep_q;
    logic cen_q;
    logic int_q;
    logic cont_q;
    logic unused_bus;

    ula_tcounter #(
        .CLK_DIV     (CLK_DIV),
        .LINE_T      (LINE_T),
        .FRAME_LINES (FRAME_LINES)
    ) u_tcounter (
        .clock (clock),
        .reset (reset),
        .tick  (tick),
        .mid   (mid),
        .line  (line),
        .col   (col)
    );

    assign unused_bus    = ^{bus.a, bus.mreq, bus.iorq};
    assign bus.cep       = cep_q;
    assign bus.cen       = cen_q;
    assign bus.int_n     = int_q;
    assign bus.contended = cont_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            int_q <= 1'b1;
        end else if (tick) begin
            int_q <= !((line == '0) && (col < INT_COLS));
        end
    end

`ifdef CPU_CONTENTION_EN
    localparam logic [8:0] WIN_L0   = 9'(CONT_LINE0);
    localparam logic [8:0] WIN_L1   = 9'(CONT_LINE0 + CONT_LINES - 1);
    localparam logic [7:0] WIN_COLS = 8'(CONT_COLS);

    sched_state_t state;
    logic         granted;
    logic         cep_last;
    logic         win;
    logic         req;

    assign win = (line >= WIN_L0) && (line <= WIN_L1) &&
                 (col < WIN_COLS) && (col[2:0] < 3'd6);
    assign req = is_contended_addr(bus.a) &&
                 (!bus.mreq || (!bus.iorq && !bus.a[0])) && !granted;

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= RUN;
            cep_q    <= 1'b0;
            cen_q    <= 1'b0;
            cont_q   <= 1'b0;
            granted  <= 1'b0;
            cep_last <= 1'b0;
        end else begin
            cep_q <= 1'b0;
            cen_q <= 1'b0;
            if (mid) cen_q <= cep_last;
            if (tick) begin
                case (state)
                    RUN: begin
                        if (req && win) begin
                            state    <= STALL;
                            cont_q   <= 1'b1;
                            cep_last <= 1'b0;
                        end else begin
                            cep_q    <= 1'b1;
                            cep_last <= 1'b1;
                        end
                    end
                    STALL: begin
                        if (!win) begin
                            state    <= RUN;
                            cont_q   <= 1'b0;
                            granted  <= 1'b1;
                            cep_q    <= 1'b1;
                            cep_last <= 1'b1;
                        end else begin
                            cep_last <= 1'b0;
                        end
                    end
                    default: state <= RUN;
                endcase
            end
            // An idle bus ends the access, so the next one may be contended again.
            if (bus.mreq && bus.iorq) granted <= 1'b0;
        end
    end
`else
    always_ff @(posedge clock) begin
        if (reset) begin
            cep_q <= 1'b0;
            cen_q <= 1'b0;
        end else begin
            cep_q <= tick;
            cen_q <= mid;
        end
    end

    assign cont_q = 1'b0;
`endif

endmodule

// File: doc/cpu_clock_scheduler.md
Name: cpu_clock_scheduler

Overview:
- Generates the Z80 positive and negative clock enables (cep/cen) from the system clock.
- Owns the 48K frame T-state timebase: 224 T-states per line, 312 lines per frame.
- Produces the frame interrupt for the CPU.
- Applies ULA memory/IO contention by withholding CPU clock enables while video fetches own contended RAM. It sits between the clock generator and the cpu instance.

Parameters:
- CLK_DIV, 8: system clocks per T-state; even, at least 4.
- LINE_T, 224: T-states per line.
- FRAME_LINES, 312: lines per frame.
- INT_LEN, 32: interrupt low width in T-states.
- CONT_LINE0, 64: first contended line.
- CONT_LINES, 192: number of contended lines.
- CONT_COLS, 128: contended T-states at the start of each line.

Ports:
- clock  in  1  system clock; one clock domain.
- reset  in  1  synchronous, active-high reset.
- a  in  16  CPU address bus.
- mreq  in  1  CPU MREQ, active-low.
- iorq  in  1  CPU IORQ, active-low.
- cep  out  1  CPU positive-edge clock enable, one system clock wide.
- cen  out  1  CPU negative-edge clock enable, one system clock wide.
- int  out  1  CPU interrupt, active-low.
- line  out  9  current line, 0..FRAME_LINES-1.
- col  out  8  current T-state within the line, 0..LINE_T-1.
- contended  out  1  high while the CPU clock is stalled.

Behaviour:
- **Reset values:** phase=0, line=0, col=0, cep=0, cen=0, int=1, contended=0, state=RUN, granted=0.
- **Phase counter:** runs 0..CLK_DIV-1 and wraps. A "tick" is phase==0.
- **Timebase:** col/line advance on every tick, whether or not the CPU is stalled; they track real time. col wraps LINE_T-1→0 and increments line. line wraps FRAME_LINES-1→0.
- **Interrupt:** int is registered and updated on ticks. It is low while line==0 and col<INT_LEN, otherwise high. The first tick after reset therefore drives int low.
- **Contention window (win):** line in [CONT_LINE0, CONT_LINE0+CONT_LINES-1], col<CONT_COLS, and col[2:0]<6.
- **Contended request (req):** a[15:14]==2'b01 AND (mreq==0 OR (iorq==0 AND a[0]==0)) AND granted==0.
- **FSM RUN:** on a tick:
  - req && win → go to STALL; no cep this tick; contended=1.
  - otherwise cep=1 for one clock.
- **FSM STALL:** on a tick:
  - !win → go to RUN; cep=1; granted=1; contended=0.
  - otherwise stay in STALL.
- **Resulting delays:** a request at col[2:0]=0..7 is delayed 6,5,4,3,2,1,0,0 T-states.
- **granted:** cleared on any clock where mreq and iorq are both high. Exactly one contention is applied per bus access.
- **cen:** asserted at phase==CLK_DIV/2 only if cep fired on the preceding tick. cep/cen always pair, and neither fires while stalled.
- **Simultaneous events:** frame wrap during STALL — int timing proceeds normally. A stall releases at the first tick where win is false, including window-end at col==CONT_COLS or line end.
- **Reset mid-stall:** returns to RUN with all values as listed under reset; the next tick issues cep.

Optional Feature:
- Macro: CPU_CONTENTION_EN.
- Defined: contention FSM as above.
- Undefined: FSM and granted are removed; cep on every tick, cen every mid-phase, contended tied 0. Timebase and int are unchanged.

Decomposition:
- Package zx48_timing_pkg: LINE_T, FRAME_LINES, INT_LEN, CONT_* constants; typedef sched_state_t {RUN, STALL}; helper function is_contended_addr(a).
- Sub-module ula_tcounter: phase/col/line counters plus the tick strobe. Shared later with the video block so fetch and contention stay aligned.

Test Plan:
- **Reset and free run:** reset high 3 clocks, then released, no requests → cep every 8 clocks, cen 4 clocks after each cep; col reaches 223 then 0, line increments.
- **Interrupt:** run a full frame → int low for exactly 32 ticks starting at line 0/col 0, high thereafter; period 69888 ticks.
- **Contention delay:** line 100, col 8 (col[2:0]=0), mreq=0, a=16'h4000 → 6 ticks without cep, contended=1, cep resumes at col 14. Repeat at col 13 → 1-tick delay; at col 14 → none.
- **Uncontended cases:** a=16'h8000, or line 10, or col 130 → no stall. IO access with a=16'h40FE, iorq=0 at line 100 col 16 → 6-tick stall; with a=16'h40FF → none.
- **Single contention per access:** hold mreq low across the release tick → granted prevents re-stall. mreq high then low again at col[2:0]=0 → stalls again.
- **Reset during STALL:** reset → state RUN, contended=0, counters 0, cep on the first tick after release. Build without CPU_CONTENTION_EN → the contention-delay scenario shows no stall.
